// File: rtl/onehot_scan_decoder.sv
// Recovers the lowest set-bit index of a captured vector by scanning one bit per clock,
// and flags zero-hot and multi-hot vectors. Valid/ready on both sides, fixed latency.
module onehot_scan_decoder #(
    parameter int WIDTH = 4,
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_index,
    output logic             out_zero,
    output logic             out_multi
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        HOLD
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] vec_q, vec_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [1:0]       ones_q, ones_d;
    logic [IDX_W-1:0] out_index_q, out_index_d;
    logic             out_zero_q, out_zero_d;
    logic             out_multi_q, out_multi_d;
    logic             bit_set;

    assign bit_set = vec_q[cnt_q];

    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        vec_d       = vec_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        ones_d      = ones_q;
        out_index_d = out_index_q;
        out_zero_d  = out_zero_q;
        out_multi_d = out_multi_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    vec_d   = in_vec;
                    cnt_d   = '0;
                    idx_d   = '0;
                    ones_d  = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (bit_set) begin
                    if (ones_q == 2'd0) idx_d = cnt_q;
                    if (ones_q != 2'd2) ones_d = ones_q + 2'd1;
                end
                // The result registers load from this cycle's updated idx/ones so HOLD sees final values.
                if (cnt_q == LAST_BIT) begin
                    out_index_d = IDX_W'(idx_d);
                    out_zero_d  = (ones_d == 2'd0);
                    out_multi_d = (ones_d == 2'd2);
                    state_d     = HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            state_q     <= IDLE;
            vec_q       <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            ones_q      <= '0;
            out_index_q <= '0;
            out_zero_q  <= 1'b0;
            out_multi_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            ones_q      <= ones_d;
            out_index_q <= out_index_d;
            out_zero_q  <= out_zero_d;
            out_multi_q <= out_multi_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == HOLD);
    assign out_index = out_index_q;
    assign out_zero  = out_zero_q;
    assign out_multi = out_multi_q;

endmodule
